alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one shared, external combinational ALU.
// Latency: request sampled at edge k, grant in cycle k+1, result held from cycle k+2 until acked.
// Backpressure: the result is held in RESP until the owner acks; requests are not sampled while busy.
module alu_arbiter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,

   // requester 0
   input  logic             req0,
   input  logic [WIDTH-1:0] src_a0,
   input  logic [WIDTH-1:0] src_b0,
   input  logic [2:0]       ctrl0,
   output logic             gnt0,
   output logic             rsp_valid0,
   input  logic             rsp_ack0,

   // requester 1
   input  logic             req1,
   input  logic [WIDTH-1:0] src_a1,
   input  logic [WIDTH-1:0] src_b1,
   input  logic [2:0]       ctrl1,
   output logic             gnt1,
   output logic             rsp_valid1,
   input  logic             rsp_ack1,

   // captured response, shared by both requesters (qualified by rsp_validN)
   output logic [WIDTH-1:0] result,
   output logic             zero,

   // shared ALU
   output logic [WIDTH-1:0] alu_src_a,
   output logic [WIDTH-1:0] alu_src_b,
   output logic [2:0]       alu_control,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_zero,

   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;

   // arbitration pointer and current transaction owner
   logic             prio;
   logic             own;

   // operand registers feeding the ALU
   logic [WIDTH-1:0] opa_q;
   logic [WIDTH-1:0] opb_q;
   logic [2:0]       ctl_q;

   // arbitration decision, meaningful only in IDLE
   logic             any_req;
   logic             win;
   logic             take;
   logic             own_ack;

   // Pick a winner: a lone requester always wins, a tie goes to the pointer.
   always_comb begin
      any_req = req0 | req1;
      win     = (req0 & req1) ? prio : req1;
      take    = (state == IDLE) & any_req;
      // only the owner's ack can close the response
      own_ack = own ? rsp_ack1 : rsp_ack0;
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic: EXEC is always a single cycle, RESP waits for the owner's ack.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (any_req) state_nxt = EXEC;
         EXEC:    state_nxt = RESP;
         RESP:    if (own_ack) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output decode: grant and response valid are steered to the owner only.
   always_comb begin
      gnt0       = 1'b0;
      gnt1       = 1'b0;
      rsp_valid0 = 1'b0;
      rsp_valid1 = 1'b0;
      busy       = (state != IDLE);
      if (state == EXEC) begin
         gnt0 = ~own;
         gnt1 =  own;
      end
      if (state == RESP) begin
         rsp_valid0 = ~own;
         rsp_valid1 =  own;
      end
   end

   // Capture the winner's operands, record ownership and flip the pointer away from the winner.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prio  <= 1'b0;
         own   <= 1'b0;
         opa_q <= '0;
         opb_q <= '0;
         ctl_q <= 3'b000;
      end else if (take) begin
         prio  <= ~win;
         own   <= win;
         opa_q <= win ? src_a1 : src_a0;
         opb_q <= win ? src_b1 : src_b0;
         ctl_q <= win ? ctrl1  : ctrl0;
      end
   end

   // Sample the ALU at the end of EXEC; the value then holds through RESP and beyond.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result <= '0;
         zero   <= 1'b0;
      end else if (state == EXEC) begin
         result <= alu_result;
         zero   <= alu_zero;
      end
   end

   // The ALU sees the operand registers at all times, so its inputs only move on a new grant.
   always_comb begin
      alu_src_a   = opa_q;
      alu_src_b   = opb_q;
      alu_control = ctl_q;
   end

endmodule
